// File: rtl/cbus_arbiter.sv
// Arbitrates NUM_MASTERS cbus masters onto a single memory-side cbus port.
// The grant is held for a whole burst; mismatched burst framing raises a sticky err_o.
module cbus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_MASTERS-1:0][76:0]     mreq_i,
    output logic [NUM_MASTERS-1:0][33:0]     mresp_o,
    output logic [76:0]                      sreq_o,
    input  logic [33:0]                      sresp_i,
    output logic                             err_o
);
    // Request layout: {valid, is_write, size[2:0], addr, strobe, data, len}; response: {ready, last, data}
    localparam int VALID_BIT = 76;
    localparam int READY_BIT = 33;
    localparam int LAST_BIT  = 32;
    localparam int GW        = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          rr_ptr_q;
    logic [4:0]             beats_q;
    logic [3:0]             len_q;
    logic                   err_q;

    logic [NUM_MASTERS-1:0] mvalid;
    logic [GW-1:0]          winner;
    logic                   any_valid;
    logic [GW-1:0]          next_ptr;
    logic                   final_beat;
    int                     idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign mvalid[gi]  = mreq_i[gi][VALID_BIT];
            assign mresp_o[gi] = (state_q == BUSY && grant_q == GW'(gi)) ? sresp_i : '0;
        end
    endgenerate

    // Round-robin keeps the first hit from rr_ptr; fixed priority lets the highest hit overwrite.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = (ROUND_ROBIN != 0) ? int'(rr_ptr_q) + k : k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (mvalid[GW'(idx)] && (ROUND_ROBIN == 0 || !any_valid)) begin
                winner    = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign next_ptr   = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + GW'(1);
    assign final_beat = (beats_q == {1'b0, len_q});
    assign sreq_o     = (state_q == BUSY) ? mreq_i[grant_q] : '0;
    assign err_o      = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= winner;
                        len_q   <= mreq_i[winner][3:0];
                        beats_q <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (sresp_i[READY_BIT]) beats_q <= beats_q + 5'd1;
                    // A master abandoning its burst releases the bus without advancing rr_ptr.
                    if (!mreq_i[grant_q][VALID_BIT]) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (sresp_i[READY_BIT]) begin
                        if (sresp_i[LAST_BIT] != final_beat) err_q <= 1'b1;
                        if (sresp_i[LAST_BIT]) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= next_ptr;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of upstream cbus masters (index 0 = instruction cache, index 1 = data cache).
REQ-002 Parameter ROUND_ROBIN, default 1, 1 = round-robin grant, 0 = fixed priority (highest index wins).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 mreq  input  NUM_MASTERS x 77  per-master cbus_req_t {valid, is_write, size[2:0], addr[31:0], strobe[3:0], data[31:0], len[3:0]}.
REQ-006 mresp  output  NUM_MASTERS x 34  per-master cbus_resp_t {ready, last, data[31:0]}.
REQ-007 sreq  output  77  cbus_req_t to the memory side.
REQ-008 sresp  input  34  cbus_resp_t from the memory side.
REQ-009 err  output  1  sticky protocol-error flag.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-011 In IDLE, sreq SHALL be all-zero and every mresp SHALL be all-zero.
REQ-012 In IDLE with at least one mreq[i].valid, the block SHALL latch the winner index into grant and enter BUSY on the next edge.
REQ-013 Round-robin mode: the winner SHALL be the first valid master found searching upward, with wrap-around, from rr_ptr.
REQ-014 Fixed-priority mode: the winner SHALL be the highest valid index.
REQ-015 In BUSY, sreq SHALL equal mreq[grant] combinationally, mresp[grant] SHALL equal sresp, and all other mresp SHALL be all-zero.
REQ-016 Non-granted masters SHALL never see ready=1; their requests are held off and are not dropped.
REQ-017 Beat counter beats (5 bits) SHALL clear on entering BUSY and increment on each cycle with sresp.ready=1 in BUSY.
REQ-018 Expected beat count SHALL be mreq[grant].len+1, where len is sampled when grant is latched (MLEN1=0, MLEN4=3, MLEN8=7, MLEN16=15).
REQ-019 On sresp.ready && sresp.last in BUSY, the block SHALL return to IDLE on the next edge and set rr_ptr = grant+1 modulo NUM_MASTERS.
REQ-020 Arbitration latency SHALL be one cycle from valid to sreq.valid; one IDLE bubble cycle SHALL separate back-to-back transactions.
REQ-021 The grant SHALL remain locked for the whole burst, even if another master asserts valid.
REQ-022 The block SHALL set err on any of:
  - sresp.last on a beat other than the expected final beat;
  - sresp.ready without last on the expected final beat;
  - mreq[grant].valid deasserted while in BUSY.
REQ-023 When mreq[grant].valid deasserts in BUSY, the block SHALL also return to IDLE on the next edge without updating rr_ptr.
REQ-024 When mreq[grant].valid deasserts in BUSY, sreq.valid SHALL follow the master's deasserted valid combinationally in that same cycle.
REQ-025 Once set, err SHALL hold until reset.
REQ-026 sresp activity while in IDLE SHALL be ignored and SHALL NOT set err.
REQ-027 A single-beat transaction (len=0, ready and last in the first BUSY cycle) SHALL complete in BUSY for exactly one cycle.

Reset
REQ-028 On resetn=0 at a clock edge, the block SHALL set: state=IDLE, grant=0, rr_ptr=0, beats=0, err=0.
REQ-029 Reset SHALL take priority over every other update.
REQ-030 A reset asserted mid-burst SHALL abandon the burst.
REQ-031 From the cycle after a reset edge, sreq and all mresp SHALL be all-zero.

Verification
REQ-032 Single master: master 1 issues a read, addr=0x80001000, len=MLEN4 -> sreq.valid rises 1 cycle later, 4 ready beats, mresp[1].last on beat 4, IDLE next cycle, err=0.
REQ-033 Simultaneous requests, ROUND_ROBIN=1, rr_ptr=0: both valid every cycle -> grants alternate 0,1,0,1, and master 1 never sees ready while master 0 is bursting.
REQ-034 Fixed priority: both valid continuously with ROUND_ROBIN=0 -> master 1 is always granted and master 0 waits.
REQ-035 Early last: len=MLEN4 and slave asserts last on beat 2 -> err=1 from the next cycle, state=IDLE.
REQ-036 Valid dropped: master 0 deasserts valid after beat 1 of 4 -> err=1, IDLE next cycle, rr_ptr unchanged.
REQ-037 Reset mid-burst: resetn=0 during beat 2 -> next cycle sreq=0, err=0, and a new request is granted normally after release.
